// File: rtl/lab3_pkg.sv
// lab3_pkg: declarations shared by the lab3 ALU datapath blocks.
// Used here by sub_16b_serial and sub_4b_slice.
//   state_t   : FSM encoding for the serial subtractor (IDLE, CALC, DONE)
//   SUB_WIDTH : operand/result width of the serial subtractor
//   SUB_NIB   : bits processed per cycle
//   SUB_STEPS : number of cycles needed to process one operand pair
`timescale 1ns/1ps
package lab3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SUB_WIDTH = 16;
  localparam int SUB_NIB   = 4;
  localparam int SUB_STEPS = SUB_WIDTH / SUB_NIB;

endpackage

// File: rtl/sub_4b_slice.sv
// sub_4b_slice: combinational two's-complement subtract slice.
// Computes {cout, d} = a4 + ~b4 + cin. A chained subtract starts with cin=1,
// and cout=0 out of the top slice means the overall result borrowed.
// Ports:
//   a4   in  W  minuend nibble
//   b4   in  W  subtrahend nibble
//   cin  in  1  carry in (inverted borrow in)
//   d    out W  difference nibble
//   cout out 1  carry out (inverted borrow out)
`timescale 1ns/1ps
module sub_4b_slice
  import lab3_pkg::*;
#(
  parameter int W = SUB_NIB
) (
  input  logic [W-1:0] a4,
  input  logic [W-1:0] b4,
  input  logic         cin,
  output logic [W-1:0] d,
  output logic         cout
);

  logic [W:0] sum;

  // One extra bit on every term so the carry out lands in sum[W].
  assign sum  = {1'b0, a4} + {1'b0, ~b4} + {{W{1'b0}}, cin};
  assign d    = sum[W-1:0];
  assign cout = sum[W];

endmodule

// File: rtl/sub_16b_serial.sv
// sub_16b_serial: sequential subtractor, diff = a - b.
// A single sub_4b_slice is reused for WIDTH/NIB cycles, one nibble per cycle,
// with the carry held in a register between cycles. Operands and results use
// a valid/ready handshake.
// Optional feature: define SUB_16B_SERIAL_SAT_EN to clamp diff to the signed
// extremes on signed overflow. When it is undefined, diff is the raw modular
// result and no clamp logic is built.
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      synchronous active-high reset
//   in_valid  in  1      operands valid
//   in_ready  out 1      ready for operands (IDLE only)
//   a         in  WIDTH  minuend
//   b         in  WIDTH  subtrahend
//   out_valid out 1      result valid (DONE only)
//   out_ready in  1      consumer accepts result
//   diff      out WIDTH  a - b (modular, or clamped with SAT_EN)
//   borrow    out 1      a < b unsigned
//   ovf       out 1      signed overflow of the raw result
//   zero      out 1      diff output equals zero
`timescale 1ns/1ps
module sub_16b_serial
  import lab3_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int NIB   = SUB_NIB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS  = WIDTH / NIB;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  state_t             state;
  logic [STEP_W-1:0]  step;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   diff_raw;
  logic               carry;

  logic [NIB-1:0]     a_nib;
  logic [NIB-1:0]     b_nib;
  logic [NIB-1:0]     d_nib;
  logic               c_nib;
  logic [WIDTH-1:0]   raw_next;
  logic               raw_ovf;
  logic [WIDTH-1:0]   diff_next;

  // Nibble select from the latched operands, and the nibble insert into the
  // running result. raw_next already holds the complete result on the last
  // step, so the flags can be registered together with the final nibble.
  always_comb begin
    a_nib    = '0;
    b_nib    = '0;
    raw_next = diff_raw;
    for (int k = 0; k < STEPS; k++) begin
      if (step == STEP_W'(k)) begin
        a_nib                  = a_reg[k*NIB +: NIB];
        b_nib                  = b_reg[k*NIB +: NIB];
        raw_next[k*NIB +: NIB] = d_nib;
      end
    end
  end

  sub_4b_slice #(.W(NIB)) u_slice (
    .a4   (a_nib),
    .b4   (b_nib),
    .cin  (carry),
    .d    (d_nib),
    .cout (c_nib)
  );

  // Overflow: operands of opposite sign and a result whose sign differs from a.
  assign raw_ovf = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                   (raw_next[WIDTH-1] != a_reg[WIDTH-1]);

`ifdef SUB_16B_SERIAL_SAT_EN
  // A negative a can only overflow downward, a non-negative a only upward.
  always_comb begin
    diff_next = raw_next;
    if (raw_ovf) begin
      diff_next = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign diff_next = raw_next;
`endif

  // FSM, step counter, carry chain and registered outputs. The result
  // registers are written only on entry to DONE, so partial results never
  // reach the outputs, and they keep their value through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      diff_raw  <= '0;
      carry     <= 1'b1;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            step     <= '0;
            carry    <= 1'b1;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          diff_raw <= raw_next;
          carry    <= c_nib;
          step     <= step + 1'b1;
          if (step == LAST_STEP) begin
            state     <= DONE;
            out_valid <= 1'b1;
            diff      <= diff_next;
            borrow    <= ~c_nib;
            ovf       <= raw_ovf;
            zero      <= (diff_next == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
